// File: rtl/clk_period_meter.sv
// Period meter for a slow asynchronous clock, counted in mclk cycles.
// Reports each period, tracks lock over consecutive good periods, flags loss.
module clk_period_meter #(
   parameter int CNT_W      = 20,
   parameter int EXP_PERIOD = 2000,
   parameter int TOL        = 4,
   parameter int LOCK_N     = 4,
   parameter int TIMEOUT    = 4000
) (
   input  logic             mclk,
   input  logic             rst,
   input  logic             clkin,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             locked,
   output logic             timeout,
   output logic [7:0]       err_cnt
);

   localparam int GW = $clog2(LOCK_N + 1);

   // Lower bound clamps at zero so a large TOL cannot wrap the window.
   localparam logic [CNT_W-1:0] LO =
      CNT_W'((EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0);
   localparam logic [CNT_W-1:0] HI      = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [GW-1:0]    GMAX    = GW'(LOCK_N);

   typedef enum logic {
      IDLE,
      MEAS
   } state_t;

   state_t state;
   state_t state_nxt;

   logic s1;
   logic s2;
   logic s3;
   logic rise;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] meas;
   logic [CNT_W-1:0] period_d;
   logic [GW-1:0]    good_cnt;
   logic [GW-1:0]    good_d;
   logic [GW-1:0]    good_inc;
   logic [7:0]       err_d;
   logic [7:0]       err_inc;
   logic             vld_d;
   logic             locked_d;
   logic             timeout_d;
   logic             in_tol;
   logic             to_hit;

   always_ff @(posedge mclk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clkin;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // The rise that ends a period lands on cnt == N-1.
   assign meas     = cnt + 1'b1;
   assign in_tol   = (meas >= LO) && (meas <= HI);
   assign to_hit   = (cnt == TO_LAST);
   assign good_inc = (good_cnt == GMAX) ? good_cnt : good_cnt + 1'b1;
   assign err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

   always_ff @(posedge mclk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = MEAS;
            end
         end
         MEAS: begin
            if (!rise && to_hit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt;
      period_d  = period;
      vld_d     = 1'b0;
      good_d    = good_cnt;
      locked_d  = locked;
      timeout_d = timeout;
      err_d     = err_cnt;
      unique case (state)
         IDLE: begin
            if (rise) begin
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         MEAS: begin
            if (rise) begin
               // A rise on the timeout cycle still counts as a period.
               period_d = meas;
               vld_d    = 1'b1;
               cnt_d    = '0;
               if (in_tol) begin
                  good_d   = good_inc;
                  locked_d = (good_inc == GMAX);
               end else begin
                  good_d   = '0;
                  locked_d = 1'b0;
                  err_d    = err_inc;
               end
            end else if (to_hit) begin
               cnt_d     = '0;
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               good_d    = '0;
               err_d     = err_inc;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         cnt        <= '0;
         period     <= '0;
         period_vld <= 1'b0;
         good_cnt   <= '0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         cnt        <= cnt_d;
         period     <= period_d;
         period_vld <= vld_d;
         good_cnt   <= good_d;
         locked     <= locked_d;
         timeout    <= timeout_d;
         err_cnt    <= err_d;
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: event-level model feeding a scoreboard queue.
// Expected reports are queued at each driven clkin rise, compared on period_vld.
module tb_clk_period_meter;

   localparam int EXP     = 2000;
   localparam int TOL     = 4;
   localparam int LOCK_N  = 4;
   localparam int TIMEOUT = 4000;

   logic        mclk = 1'b0;
   logic        rst;
   logic        clkin;
   logic [19:0] period;
   logic        period_vld;
   logic        locked;
   logic        timeout;
   logic [7:0]  err_cnt;

   typedef struct {
      int p;
      int lk;
      int e;
   } exp_t;

   exp_t q[$];

   int n_chk  = 0;
   int n_fail = 0;
   int m_good = 0;
   int m_err  = 0;
   int m_lk   = 0;
   int prev   = 0;
   bit m_idle = 1'b1;
   bit to_pend = 1'b0;

   clk_period_meter dut (
      .mclk       (mclk),
      .rst        (rst),
      .clkin      (clkin),
      .period     (period),
      .period_vld (period_vld),
      .locked     (locked),
      .timeout    (timeout),
      .err_cnt    (err_cnt)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] req);
      n_chk++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
      end
   endtask

   always @(negedge mclk) begin
      exp_t e;
      if (period_vld) begin
         if (q.size() == 0) begin
            chk("vld_queue", 32'(q.size()), 32'd1);
         end else begin
            e = q.pop_front();
            chk("period", 32'(period), 32'(e.p));
            chk("locked", 32'(locked), 32'(e.lk));
            chk("err_cnt", 32'(err_cnt), 32'(e.e));
            chk("to_at_vld", 32'(timeout), 32'd0);
         end
      end
   end

   task automatic model_rise();
      exp_t e;
      if (m_idle) begin
         m_idle = 1'b0;
      end else begin
         if (prev >= EXP - TOL && prev <= EXP + TOL) begin
            m_good = (m_good < LOCK_N) ? m_good + 1 : LOCK_N;
            m_lk   = (m_good == LOCK_N) ? 1 : 0;
         end else begin
            m_good = 0;
            m_lk   = 0;
            m_err  = (m_err < 255) ? m_err + 1 : 255;
         end
         e.p  = prev;
         e.lk = m_lk;
         e.e  = m_err;
         q.push_back(e);
      end
   endtask

   // One clkin period of p mclk cycles, starting with a rise.
   task automatic cyc(input int p, input int rst_at = 0);
      int h;
      h = (p / 2 > 1000) ? 1000 : p / 2;
      model_rise();
      prev  = p;
      clkin = 1'b1;
      for (int k = 1; k <= p; k++) begin
         @(negedge mclk);
         if (k == h) clkin = 1'b0;
         if (to_pend && k == 2) chk("to_hold", 32'(timeout), 32'd1);
         if (to_pend && k == 3) begin
            chk("to_clear", 32'(timeout), 32'd0);
            to_pend = 1'b0;
         end
         if (p > TIMEOUT && k == TIMEOUT + 2) begin
            chk("to_early", 32'(timeout), 32'd0);
            chk("lk_pre_to", 32'(locked), 32'(m_lk));
         end
         if (p > TIMEOUT && k == TIMEOUT + 3) begin
            m_err  = (m_err < 255) ? m_err + 1 : 255;
            m_lk   = 0;
            m_good = 0;
            m_idle = 1'b1;
            to_pend = 1'b1;
            chk("to_set", 32'(timeout), 32'd1);
            chk("to_lock", 32'(locked), 32'd0);
            chk("to_err", 32'(err_cnt), 32'(m_err));
         end
         if (rst_at != 0 && k == rst_at) rst = 1'b1;
         if (rst_at != 0 && k == rst_at + 1) begin
            rst = 1'b0;
            m_idle = 1'b1;
            m_lk   = 0;
            m_good = 0;
            m_err  = 0;
            chk("rst_period", 32'(period), 32'd0);
            chk("rst_vld", 32'(period_vld), 32'd0);
            chk("rst_locked", 32'(locked), 32'd0);
            chk("rst_timeout", 32'(timeout), 32'd0);
            chk("rst_err", 32'(err_cnt), 32'd0);
         end
      end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      clkin = 1'b0;
      repeat (3) @(negedge mclk);
      chk("init_period", 32'(period), 32'd0);
      chk("init_vld", 32'(period_vld), 32'd0);
      chk("init_locked", 32'(locked), 32'd0);
      chk("init_timeout", 32'(timeout), 32'd0);
      chk("init_err", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      @(negedge mclk);

      repeat (5) cyc(2000);
      cyc(1996);
      cyc(2004);
      cyc(1996);
      cyc(2005);
      repeat (4) cyc(2000);
      cyc(6000);
      cyc(2000);
      cyc(2000);
      cyc(4000);
      repeat (5) cyc(2000);
      cyc(2000, 1500);
      cyc(2000);
      cyc(2000);
      repeat (300) cyc(20);
      cyc(2000);

      repeat (10) @(negedge mclk);
      chk("queue_drain", 32'(q.size()), 32'd0);
      chk("err_sat", 32'(err_cnt), 32'd255);
      chk("lock_final", 32'(locked), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
